// File: rtl/qpsk_pkg.sv
// Shared constants and state encoding for the QPSK demodulator sequencer.
package qpsk_pkg;
  localparam int QPSK_SYMS  = 11;
  localparam int QPSK_OUT_W = 21;

  typedef enum logic [1:0] {COLLECT, CAPTURE, HOLD} qpsk_ctrl_state_t;
endpackage

// File: rtl/qpsk_demodulator.sv
// Combinational 11-symbol QPSK demodulator: each symbol maps to {~I, ~Q},
// symbols concatenated 10 down to 0 with the final ~Q0 bit dropped.
module qpsk_demodulator
  import qpsk_pkg::*;
(
  input  logic [QPSK_SYMS-1:0]  re_bits,
  input  logic [QPSK_SYMS-1:0]  im_bits,
  output logic [QPSK_OUT_W-1:0] data
);
  always_comb begin
    data    = '0;
    data[0] = ~re_bits[0];
    for (int k = 1; k < QPSK_SYMS; k++) begin
      data[2*k-1] = ~im_bits[k];
      data[2*k]   = ~re_bits[k];
    end
  end
endmodule

// File: rtl/qpsk_demod_ctrl.sv
// Sequencer: collects 11 I/Q sign decisions, runs the demodulator once per
// word, registers the result and offers it downstream.
module qpsk_demod_ctrl
  import qpsk_pkg::*;
#(
  parameter int SYMS_PER_WORD  = 11,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  sym_valid,
  input  logic                  sym_i,
  input  logic                  sym_q,
  output logic                  sym_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QPSK_OUT_W-1:0] out_data,
  output logic                  word_dropped,
  output logic [CNT_W-1:0]      word_count,
  output qpsk_ctrl_state_t      state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // out_valid, once high, holds with out_data stable until the transfer.
  generate
    if (SYMS_PER_WORD != QPSK_SYMS) begin : g_bad_syms
      $error("SYMS_PER_WORD must equal 11");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 2..65535");
    end
  endgenerate

  localparam logic [15:0]      IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_SYM  = 4'(QPSK_SYMS - 1);
  localparam logic [CNT_W-1:0] WC_ONE    = CNT_W'(1);

  qpsk_ctrl_state_t        state_n;
  logic [3:0]              sym_count, sym_count_n, base;
  logic [15:0]             idle_cnt, idle_cnt_n;
  logic [QPSK_SYMS-1:0]    real_reg, real_n, imag_reg, imag_n;
  logic [QPSK_OUT_W-1:0]   out_data_n, demod_data;
  logic                    out_valid_n, word_dropped_n;
  logic [CNT_W-1:0]        word_count_n;
  logic                    accept, restart, timeout;

  qpsk_demodulator u_demod (
    .re_bits (real_reg),
    .im_bits (imag_reg),
    .data    (demod_data)
  );

  assign sym_ready = (state == COLLECT);
  assign accept    = sym_valid && sym_ready;

  always_comb begin
    state_n        = state;
    sym_count_n    = sym_count;
    idle_cnt_n     = idle_cnt;
    real_n         = real_reg;
    imag_n         = imag_reg;
    out_data_n     = out_data;
    out_valid_n    = out_valid;
    word_dropped_n = 1'b0;
    word_count_n   = word_count;
    restart        = 1'b0;
    timeout        = 1'b0;
    base           = sym_count;
    case (state)
      COLLECT: begin
        restart = frame_start && (sym_count != 4'd0);
        timeout = (sym_count != 4'd0) && !accept && (idle_cnt == IDLE_LAST);
        word_dropped_n = restart || timeout;
        // A realignment or discard means the next symbol lands at index 0.
        if (frame_start || timeout) base = 4'd0;
        if (accept) begin
          real_n[base] = sym_i;
          imag_n[base] = sym_q;
          idle_cnt_n   = 16'd0;
          if (base == LAST_SYM) begin
            sym_count_n = 4'd0;
            state_n     = CAPTURE;
          end else begin
            sym_count_n = base + 4'd1;
          end
        end else begin
          sym_count_n = base;
          if (restart || timeout || sym_count == 4'd0) idle_cnt_n = 16'd0;
          else                                         idle_cnt_n = idle_cnt + 16'd1;
        end
      end
      CAPTURE: begin
        out_data_n  = demod_data;
        out_valid_n = 1'b1;
        state_n     = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_n  = 1'b0;
          word_count_n = word_count + WC_ONE;
          state_n      = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      sym_count    <= 4'd0;
      idle_cnt     <= 16'd0;
      real_reg     <= '0;
      imag_reg     <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      word_dropped <= 1'b0;
      word_count   <= '0;
    end else begin
      state        <= state_n;
      sym_count    <= sym_count_n;
      idle_cnt     <= idle_cnt_n;
      real_reg     <= real_n;
      imag_reg     <= imag_n;
      out_data     <= out_data_n;
      out_valid    <= out_valid_n;
      word_dropped <= word_dropped_n;
      word_count   <= word_count_n;
    end
  end
endmodule

// File: tb/tb_qpsk_demod_ctrl.sv
// Self-checking bench for qpsk_demod_ctrl: vector table, corner sequences and
// randomized words against a symbol-level reference model.
module tb_qpsk_demod_ctrl;
  import qpsk_pkg::*;

  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst, frame_start, sym_valid, sym_i, sym_q, out_ready;
  logic             sym_ready, out_valid, word_dropped;
  logic [20:0]      out_data;
  logic [15:0]      word_count;
  qpsk_ctrl_state_t state;

  qpsk_demod_ctrl #(.SYMS_PER_WORD(11), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .sym_valid    (sym_valid),
    .sym_i        (sym_i),
    .sym_q        (sym_q),
    .sym_ready    (sym_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .word_dropped (word_dropped),
    .word_count   (word_count),
    .state        (state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int drops = 0;
  int exp_wc = 0;
  logic [20:0] exp_q[$];

  always @(negedge clk) if (word_dropped) drops++;

  typedef struct {
    logic [10:0] i;
    logic [10:0] q;
    logic [20:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Symbol-level model: each symbol contributes {~I,~Q}, symbol 10 first,
  // and the trailing ~Q0 is dropped.
  function automatic logic [20:0] model(input logic [10:0] i, input logic [10:0] q);
    logic [21:0] bits = '0;
    for (int k = 10; k >= 0; k--) bits = {bits[19:0], ~i[k], ~q[k]};
    return bits[21:1];
  endfunction

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0; sym_valid = 1'b0;
    sym_i = 1'b0; sym_q = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send_sym(input logic i, input logic q, input logic fs);
    frame_start = fs; sym_valid = 1'b1; sym_i = i; sym_q = q;
    step();
    sym_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 40 && !sym_ready; n++) step();
    check("sym_ready_wait", sym_ready, 1);
  endtask

  task automatic send_word(input logic [10:0] i, input logic [10:0] q, input int max_gap);
    wait_ready();
    for (int k = 0; k < 11; k++) begin
      send_sym(i[k], q[k], 1'b0);
      if (k < 10) repeat ($urandom_range(0, max_gap)) step();
    end
    exp_q.push_back(model(i, q));
  endtask

  task automatic recv_word(input string name, input int stall);
    logic [20:0] d;
    logic [20:0] e;
    for (int n = 0; n < 20 && !out_valid; n++) step();
    check({name, "_valid"}, out_valid, 1);
    repeat (stall) step();
    d = out_data;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_wc++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h0;
    check({name, "_data"}, d, e);
    check({name, "_count"}, word_count, exp_wc);
  endtask

  initial begin
    logic [10:0] ri, rq;
    int d0;
    vecs[0] = '{11'h7FF, 11'h7FF, 21'h000000};
    vecs[1] = '{11'h000, 11'h000, 21'h1FFFFF};
    vecs[2] = '{11'h7FE, 11'h7FF, 21'h000001};
    vecs[3] = '{11'h7FF, 11'h000, 21'h0AAAAA};
    vecs[4] = '{11'h000, 11'h7FF, 21'h155555};
    vecs[5] = '{11'h7FD, 11'h7FF, 21'h000004};

    rst = 1'b1; frame_start = 1'b0; sym_valid = 1'b0;
    sym_i = 1'b0; sym_q = 1'b0; out_ready = 1'b0;
    step();
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_word_count", word_count, 0);
    check("rst_sym_ready", sym_ready, 1);
    check("rst_word_dropped", word_dropped, 0);
    check("rst_state", 32'(state), 32'(COLLECT));

    // Table vectors with out_ready held high: latency and 13-cycle cadence.
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 11; k++) send_sym(vecs[v].i[k], vecs[v].q[k], 1'b0);
      check("vec_capture_not_valid", out_valid, 0);
      check("vec_capture_not_ready", sym_ready, 0);
      step();
      check("vec_latency_valid", out_valid, 1);
      check("vec_data", out_data, vecs[v].exp);
      step();
      exp_wc++;
      check("vec_handshake_clear", out_valid, 0);
      check("vec_count", word_count, exp_wc);
      check("vec_ready_back", sym_ready, 1);
    end
    out_ready = 1'b0;

    // Backpressure: word held 20 cycles, symbols and frame_start ignored.
    d0 = drops;
    send_word(11'h5A3, 11'h1C6, 0);
    for (int n = 0; n < 20 && !out_valid; n++) step();
    check("hold_valid", out_valid, 1);
    for (int c = 0; c < 20; c++) begin
      sym_valid = 1'b1; sym_i = 1'($urandom); sym_q = 1'($urandom);
      frame_start = (c == 7);
      step();
      check("hold_stable_valid", out_valid, 1);
      check("hold_stable_data", out_data, exp_q[0]);
      check("hold_sym_ready", sym_ready, 0);
    end
    sym_valid = 1'b0; frame_start = 1'b0;
    recv_word("hold", 0);
    step();
    check("hold_single_handshake", word_count, exp_wc);
    check("hold_no_drop", drops, d0);
    send_word(11'h2B7, 11'h64D, 0);
    recv_word("after_hold", 1);

    // frame_start with a symbol after 5 accepts: one drop, fs symbol is index 0.
    d0 = drops;
    ri = 11'($urandom); rq = 11'($urandom);
    wait_ready();
    for (int k = 0; k < 5; k++) send_sym(1'($urandom), 1'($urandom), 1'b0);
    send_sym(ri[0], rq[0], 1'b1);
    check("fs_drop_pulse", word_dropped, 1);
    for (int k = 1; k < 11; k++) begin
      send_sym(ri[k], rq[k], 1'b0);
      if (k == 1) check("fs_drop_one_cycle", word_dropped, 0);
    end
    exp_q.push_back(model(ri, rq));
    recv_word("fs", 2);
    check("fs_drop_count", drops, d0 + 1);

    // Timeout: 3 symbols then 8 idle cycles.
    d0 = drops;
    wait_ready();
    for (int k = 0; k < 3; k++) send_sym(1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      step();
      check("to_no_early_drop", word_dropped, 0);
    end
    step();
    check("to_drop_8th", word_dropped, 1);
    check("to_state", 32'(state), 32'(COLLECT));
    send_word(11'h3E1, 11'h0F7, 2);
    recv_word("to_after", 0);
    check("to_drop_count", drops, d0 + 1);

    // Accept on exactly the timeout cycle: no drop, 11-symbol word completes.
    d0 = drops;
    ri = 11'($urandom); rq = 11'($urandom);
    wait_ready();
    for (int k = 0; k < 3; k++) send_sym(ri[k], rq[k], 1'b0);
    repeat (7) step();
    send_sym(ri[3], rq[3], 1'b0);
    check("to_accept_wins", word_dropped, 0);
    for (int k = 4; k < 11; k++) send_sym(ri[k], rq[k], 1'b0);
    exp_q.push_back(model(ri, rq));
    recv_word("to_accept", 0);
    check("to_accept_no_drop", drops, d0);

    // Timeout and frame_start together: a single pulse.
    d0 = drops;
    wait_ready();
    for (int k = 0; k < 3; k++) send_sym(1'b1, 1'b0, 1'b0);
    repeat (7) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    check("to_fs_single_pulse", drops, d0 + 1);

    // Randomized words against the model.
    for (int w = 0; w < 30; w++) begin
      send_word(11'($urandom), 11'($urandom), 3);
      recv_word("rand", $urandom_range(0, 3));
    end

    // Reset while holding a word: word lost, no drop pulse.
    d0 = drops;
    send_word(11'h111, 11'h222, 0);
    for (int n = 0; n < 20 && !out_valid; n++) step();
    check("rst_hold_valid", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_front());
    exp_wc = 0;
    check("rst_hold_out_valid", out_valid, 0);
    check("rst_hold_word_count", word_count, 0);
    check("rst_hold_sym_ready", sym_ready, 1);
    check("rst_hold_word_dropped", word_dropped, 0);
    step();
    check("rst_hold_no_drop", drops, d0);
    send_word(11'h0AB, 11'h7C0, 1);
    recv_word("post_rst", 0);

    // ---- final report ----
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
